// File: rtl/aes_ctrl_pkg.sv
// Shared types and helpers for the AES request scheduler: FSM state encoding,
// default requester count and the round-robin search used by the arbiter.
package aes_ctrl_pkg;

    localparam int DEF_N_REQ = 4;
    localparam int MAX_REQ   = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_BUSY  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // First set bit of pend scanning upward from last+1, wrapping at n.
    // last < n always holds, so one conditional subtract replaces a modulo.
    function automatic logic [3:0] rr_next(input logic [MAX_REQ-1:0] pend,
                                           input logic [3:0]         last,
                                           input int                 n);
        logic [3:0] pick;
        logic       hit;
        int         j;
        pick = last;
        hit  = 1'b0;
        for (int i = 1; i <= MAX_REQ; i++) begin
            j = int'(last) + i;
            if (j >= n) j = j - n;
            if (!hit && (i <= n) && pend[j[3:0]]) begin
                pick = j[3:0];
                hit  = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/req_edge_capture.sv
// Per-requester falling-edge detector with a sticky pending bit and a
// registered "merged edge" pulse; a set on the same edge as a clear wins.
module req_edge_capture
    import aes_ctrl_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req_i,
    input  logic [N_REQ-1:0] clr_i,
    output logic [N_REQ-1:0] pending_o,
    output logic [N_REQ-1:0] missed_o
);

    for (genvar k = 0; k < N_REQ; k++) begin : g_lane
        logic prev_q, pend_q, miss_q, fall;

        assign fall = prev_q & ~req_i[k];

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                prev_q <= 1'b0;
                pend_q <= 1'b0;
                miss_q <= 1'b0;
            end else begin
                prev_q <= req_i[k];
                pend_q <= fall | (pend_q & ~clr_i[k]);
                // An edge landing on the clear cycle is a fresh job, not a merge.
                miss_q <= fall & pend_q & ~clr_i[k];
            end
        end

        assign pending_o[k] = pend_q;
        assign missed_o[k]  = miss_q;
    end

endmodule

// File: rtl/aes_req_scheduler.sv
// Round-robin scheduler sharing one AES core between N_REQ requesters.
// Optional watchdog abort in BUSY: define AES_REQ_SCHEDULER_TIMEOUT_EN.
module aes_req_scheduler
    import aes_ctrl_pkg::*;
#(
    parameter int N_REQ       = DEF_N_REQ,
    parameter int IDX_W       = $clog2(N_REQ),
    parameter int TIMEOUT_CYC = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req_i,
    input  logic             core_done_i,
    output logic             core_start_o,
    output logic [N_REQ-1:0] grant_o,
    output logic [IDX_W-1:0] grant_idx_o,
    output logic [N_REQ-1:0] ack_o,
    output logic [N_REQ-1:0] missed_o,
    output logic             busy_o,
    output logic             timeout_o
);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   gidx_q, gidx_d, last_q, last_d, pick;
    logic [N_REQ-1:0]   grant_q, grant_d, clr, pending;

`ifdef AES_REQ_SCHEDULER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               tmo_q, tmo_d;
`endif

    req_edge_capture #(.N_REQ(N_REQ)) u_edge (
        .clk       (clk),
        .reset     (reset),
        .req_i     (req_i),
        .clr_i     (clr),
        .pending_o (pending),
        .missed_o  (missed_o)
    );

    assign pick = IDX_W'(rr_next(MAX_REQ'(pending), 4'(last_q), N_REQ));

    always_comb begin
        state_d = state_q;
        gidx_d  = gidx_q;
        grant_d = grant_q;
        last_d  = last_q;
        clr     = '0;
`ifdef AES_REQ_SCHEDULER_TIMEOUT_EN
        cnt_d   = cnt_q;
        tmo_d   = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (|pending) begin
                    gidx_d  = pick;
                    grant_d = N_REQ'(1) << pick;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                clr     = grant_q;
                state_d = ST_BUSY;
`ifdef AES_REQ_SCHEDULER_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            ST_BUSY: begin
                // Done is checked first so it beats a coincident watchdog expiry.
                if (core_done_i) state_d = ST_DONE;
`ifdef AES_REQ_SCHEDULER_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    tmo_d   = 1'b1;
                    last_d  = gidx_q;
                    grant_d = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            ST_DONE: begin
                last_d  = gidx_q;
                grant_d = '0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            gidx_q  <= '0;
            grant_q <= '0;
            last_q  <= IDX_W'(N_REQ - 1);
`ifdef AES_REQ_SCHEDULER_TIMEOUT_EN
            cnt_q   <= '0;
            tmo_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            gidx_q  <= gidx_d;
            grant_q <= grant_d;
            last_q  <= last_d;
`ifdef AES_REQ_SCHEDULER_TIMEOUT_EN
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
`endif
        end
    end

    // Decoded from the async-reset state so start/ack drop the instant reset asserts.
    assign core_start_o = (state_q == ST_START);
    assign ack_o        = (state_q == ST_DONE) ? grant_q : '0;
    assign busy_o       = (state_q != ST_IDLE);
    assign grant_o      = grant_q;
    assign grant_idx_o  = gidx_q;

`ifdef AES_REQ_SCHEDULER_TIMEOUT_EN
    assign timeout_o = tmo_q;
`else
    assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_aes_req_scheduler.sv
// Randomized + directed bench for aes_req_scheduler against a job-level
// reference model (pending set, owner, round-robin search by modulo scan).
module tb_aes_req_scheduler;

    localparam int N  = 4;
    localparam int IW = $clog2(N);
`ifdef AES_REQ_SCHEDULER_TIMEOUT_EN
    localparam int TCYC   = 8;
    localparam bit TMO_EN = 1'b1;
`else
    localparam int TCYC   = 255;
    localparam bit TMO_EN = 1'b0;
`endif
    localparam int P_IDLE = 0, P_START = 1, P_BUSY = 2, P_DONE = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [N-1:0]  req_i = '0;
    logic          core_done_i = 1'b0;
    logic          core_start_o, busy_o, timeout_o;
    logic [N-1:0]  grant_o, ack_o, missed_o;
    logic [IW-1:0] grant_idx_o;

    aes_req_scheduler #(.N_REQ(N), .TIMEOUT_CYC(TCYC)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_i        (req_i),
        .core_done_i  (core_done_i),
        .core_start_o (core_start_o),
        .grant_o      (grant_o),
        .grant_idx_o  (grant_idx_o),
        .ack_o        (ack_o),
        .missed_o     (missed_o),
        .busy_o       (busy_o),
        .timeout_o    (timeout_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    // reference model state
    logic [N-1:0] m_pend, m_prev, e_missed, cur;
    int           m_phase, m_owner, m_last, m_bcnt, m_lat, lat_force;
    bit           e_tmo, spur;

    // observation tallies
    int n_start, n_tmo, cyc_no, start_cyc, tmo_cyc;
    int n_ack[N], n_miss[N];
    int seq[$];

    function automatic logic [N-1:0] oh(input int k);
        return (k < 0) ? '0 : (N'(1) << k);
    endfunction

    task automatic model_reset();
        m_pend = '0; m_prev = '0; e_missed = '0; e_tmo = 1'b0;
        m_phase = P_IDLE; m_owner = -1; m_last = N - 1; m_bcnt = 0; m_lat = 0;
    endtask

    task automatic clear_tally();
        n_start = 0; n_tmo = 0; start_cyc = -1; tmo_cyc = -1;
        seq.delete();
        for (int k = 0; k < N; k++) begin n_ack[k] = 0; n_miss[k] = 0; end
    endtask

    task automatic model_step(input logic [N-1:0] r, input logic d);
        logic [N-1:0] fall, clr;
        fall     = m_prev & ~r;
        clr      = (m_phase == P_START) ? oh(m_owner) : '0;
        e_missed = fall & m_pend & ~clr;
        e_tmo    = 1'b0;
        case (m_phase)
            P_IDLE: if (m_pend != '0) begin
                for (int i = 1; i <= N; i++)
                    if (m_pend[(m_last + i) % N]) begin m_owner = (m_last + i) % N; break; end
                m_phase = P_START;
            end
            P_START: begin
                m_phase = P_BUSY; m_bcnt = 0;
                m_lat = (lat_force >= 0) ? lat_force : int'($urandom_range(0, 11));
            end
            P_BUSY: begin
                if (d) m_phase = P_DONE;
                else if (TMO_EN && m_bcnt == TCYC - 1) begin
                    e_tmo = 1'b1; m_last = m_owner; m_owner = -1; m_phase = P_IDLE;
                end else m_bcnt++;
            end
            default: begin m_last = m_owner; m_owner = -1; m_phase = P_IDLE; end
        endcase
        m_pend = fall | (m_pend & ~clr);
        m_prev = r;
    endtask

    task automatic compare_all();
        chk("core_start", 32'(core_start_o), 32'(m_phase == P_START));
        chk("grant",      32'(grant_o),      32'(oh(m_owner)));
        if (m_owner >= 0) chk("grant_idx", 32'(grant_idx_o), 32'(m_owner));
        chk("ack",        32'(ack_o),        32'((m_phase == P_DONE) ? oh(m_owner) : '0));
        chk("missed",     32'(missed_o),     32'(e_missed));
        chk("busy",       32'(busy_o),       32'(m_phase != P_IDLE));
        chk("timeout",    32'(timeout_o),    32'(e_tmo));
        if (core_start_o) begin
            n_start++; seq.push_back(int'(grant_idx_o));
            if (start_cyc < 0) start_cyc = cyc_no;
        end
        if (timeout_o) begin n_tmo++; if (tmo_cyc < 0) tmo_cyc = cyc_no; end
        for (int k = 0; k < N; k++) begin
            if (ack_o[k])    n_ack[k]++;
            if (missed_o[k]) n_miss[k]++;
        end
    endtask

    // One clock: drive at negedge, model steps at posedge, compare at next negedge.
    task automatic tick(input logic [N-1:0] r);
        logic d;
        d = (m_phase == P_BUSY) && (m_bcnt >= m_lat);
        if (spur && (m_phase == P_IDLE || m_phase == P_START) && $urandom_range(0, 5) == 0) d = 1'b1;
        cur = r; req_i = r; core_done_i = d;
        @(posedge clk);
        model_step(r, d);
        @(negedge clk);
        cyc_no++;
        compare_all();
    endtask

    task automatic do_reset(input string tag);
        core_done_i = 1'b0;
        reset = 1'b0;
        #1;
        chk(tag, 32'({core_start_o, grant_o, grant_idx_o, ack_o, missed_o, busy_o, timeout_o}), 32'd0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic run_idle(input string tag, input int max);
        for (int i = 0; i < max; i++) begin
            if (m_phase == P_IDLE && m_pend == '0) break;
            tick(cur);
        end
        chk(tag, 32'(busy_o), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t got=running exp=finished", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        spur = 1'b0; lat_force = -1; cyc_no = 0; cur = '0;
        model_reset(); clear_tally();
        #1;
        do_reset("reset_state");

        // single job on requester 2
        clear_tally(); lat_force = TMO_EN ? 5 : 9;
        tick(4'b0100); tick(4'b0000);
        run_idle("t1_idle", 60);
        chk("t1_starts", 32'(n_start), 32'd1);
        chk("t1_ack2",   32'(n_ack[2]), 32'd1);
        chk("t1_idx",    32'(seq.size() > 0 ? seq[0] : -1), 32'd2);

        // all four pending at once
        do_reset("t2_reset"); clear_tally(); lat_force = -1;
        tick(4'hF); tick(4'h0);
        run_idle("t2_idle", 200);
        chk("t2_starts", 32'(n_start), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("t2_order", 32'(seq.size() > i ? seq[i] : -1), 32'(i));
            chk("t2_ack",   32'(n_ack[i]), 32'd1);
            chk("t2_miss",  32'(n_miss[i]), 32'd0);
        end

        // merged edges on requester 1 while 0 is served
        do_reset("t3_reset"); clear_tally(); lat_force = 6;
        tick(4'b0011); tick(4'b0010); tick(4'b0000); tick(4'b0010); tick(4'b0000);
        run_idle("t3_idle", 60);
        chk("t3_miss1", 32'(n_miss[1]), 32'd1);
        chk("t3_ack1",  32'(n_ack[1]), 32'd1);
        chk("t3_ack0",  32'(n_ack[0]), 32'd1);

        // requester 0 re-posts during its own BUSY
        do_reset("t4_reset"); clear_tally(); lat_force = 6;
        tick(4'b0111); tick(4'b0000);
        for (int i = 0; i < 10 && !(m_phase == P_BUSY && m_owner == 0); i++) tick(cur);
        chk("t4_busy0", 32'(grant_o), 32'b0001);
        tick(4'b0001); tick(4'b0000);
        run_idle("t4_idle", 100);
        chk("t4_ack0",  32'(n_ack[0]), 32'd2);
        chk("t4_miss0", 32'(n_miss[0]), 32'd0);
        for (int i = 0; i < 4; i++)
            chk("t4_order", 32'(seq.size() > i ? seq[i] : -1), 32'((i == 3) ? 0 : i));

        // reset in BUSY: no ack afterwards, fresh edge served
        clear_tally(); lat_force = 50;
        tick(4'b1000); tick(4'b0000);
        for (int i = 0; i < 10 && m_phase != P_BUSY; i++) tick(cur);
        tick(cur); tick(cur);
        chk("t5_in_busy", 32'(busy_o), 32'd1);
        do_reset("t5_reset_outs"); clear_tally();
        for (int i = 0; i < 20; i++) tick(4'b0000);
        chk("t5_no_ack",   32'(n_ack[0] + n_ack[1] + n_ack[2] + n_ack[3]), 32'd0);
        chk("t5_no_start", 32'(n_start), 32'd0);
        lat_force = 3;
        tick(4'b0010); tick(4'b0000);
        run_idle("t5_idle", 40);
        chk("t5_ack1", 32'(n_ack[1]), 32'd1);

`ifdef AES_REQ_SCHEDULER_TIMEOUT_EN
        // core never answers: both jobs abort without ack
        do_reset("t6_reset"); clear_tally(); lat_force = 1000;
        tick(4'b0011); tick(4'b0000);
        run_idle("t6_idle", 100);
        chk("t6_tmo",   32'(n_tmo), 32'd2);
        chk("t6_acks",  32'(n_ack[0] + n_ack[1]), 32'd0);
        chk("t6_dist",  32'(tmo_cyc - start_cyc), 32'd9);
        chk("t6_next",  32'(seq.size() > 1 ? seq[1] : -1), 32'd1);
`endif

        // random traffic with spurious done outside BUSY
        do_reset("t7_reset"); clear_tally(); lat_force = -1; spur = 1'b1;
        for (int i = 0; i < 600; i++) begin
            logic [N-1:0] flip;
            for (int k = 0; k < N; k++) flip[k] = ($urandom_range(0, 4) == 0);
            tick(cur ^ flip);
        end
        spur = 1'b0;
        run_idle("t7_drain", 400);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/aes_req_scheduler.md
Name: aes_req_scheduler

Overview:
- Shares a single AES core between N_REQ requesters.
- Each requester signals a job by a falling edge on its level request line. The block captures the edge into a sticky pending bit and grants the core round-robin.
- For each grant it issues a one-cycle core start, waits for core done, then returns a one-cycle ack to the granted requester.
- Sits between the per-channel request logic and the AES core start/done interface.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- IDX_W, $clog2(N_REQ), width of grant index.
- TIMEOUT_CYC, 255, watchdog limit in cycles while BUSY (used only with the optional feature).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_i  input  N_REQ  per-requester level request; a falling edge (1->0) posts a job.
- core_done_i  input  1  AES core completion pulse.
- core_start_o  output  1  one-cycle start pulse to AES core.
- grant_o  output  N_REQ  one-hot owner of the core; all-zero when idle.
- grant_idx_o  output  IDX_W  binary index of current owner.
- ack_o  output  N_REQ  one-cycle completion pulse to the owner.
- missed_o  output  N_REQ  one-cycle pulse: falling edge arrived while that requester's pending bit was already set.
- busy_o  output  1  high in every state except IDLE.
- timeout_o  output  1  one-cycle pulse on watchdog abort (optional feature; tied 0 otherwise).

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on port reset; all flops clear immediately on reset low.
- Reset values: outputs 0, pending 0, last_grant = N_REQ-1 (so the first grant searches from index 0), req_prev 0, state IDLE.
- Edge capture: req_prev[k] registers req_i[k] every cycle. A falling edge (req_prev=1, req_i=0) at clock edge E sets pending[k] at E. A rising edge, or a level held high, posts nothing.
- Merged edges: an edge while pending[k]=1 is merged (no queuing) and pulses missed_o[k] in the same cycle.
- Set-over-clear: if a new edge for k coincides with the clear of pending[k], set wins and pending stays 1.
- FSM states: IDLE, START, BUSY, DONE.
- IDLE: if any pending bit is set, select the first set bit scanning from last_grant+1 modulo N_REQ, register grant_idx/grant_o, go to START. Otherwise stay.
- START: core_start_o=1 for exactly this cycle, pending[grant] cleared, go to BUSY.
- BUSY: wait for core_done_i=1, then go to DONE. core_done_i is ignored in IDLE and START.
- DONE: ack_o[grant]=1 for this cycle, last_grant <= grant_idx, grant_o cleared at exit, go to IDLE.
- Latency: edge sampled at E -> grant visible after E+1 -> core_start_o high during the cycle after E+1. Minimum request-to-ack is 4 cycles plus core latency.
- grant_o/grant_idx_o are stable from START through DONE inclusive.
- Fairness: a requester that just completed has the lowest priority in the next search. With all N_REQ pending, grants rotate 0,1,...,N_REQ-1,0.
- Reset mid-operation: core_start_o and ack_o drop asynchronously. Pending jobs are lost, and no ack is issued for the interrupted job.

Optional Feature:
- Macro: AES_REQ_SCHEDULER_TIMEOUT_EN.
- With macro: a cycle counter, cleared on entry to BUSY, increments each BUSY cycle. When it reaches TIMEOUT_CYC without core_done_i: pulse timeout_o, skip DONE (no ack), set last_grant, return to IDLE. If core_done_i and the limit occur in the same cycle, done wins.
- Without macro: no counter, BUSY waits indefinitely, timeout_o tied 0.

Decomposition:
- Package aes_ctrl_pkg: FSM state typedef (2-bit encoding), default N_REQ, and a round-robin next-index helper function.
- Sub-module req_edge_capture: N_REQ-wide req_prev/pending/missed logic with a set/clear interface. The FSM and arbiter stay in the top.

Test Plan:
- Single job: req_i[2] 1->0 with core_done 10 cycles after start -> exactly one core_start_o; grant_o=4'b0100, grant_idx_o=2; ack_o[2] pulse 1 cycle after core_done; back to IDLE, busy_o=0.
- All pending: falling edges on req_i[3:0] in the same cycle -> grants in order 0,1,2,3, one start each, four acks, no missed_o.
- Merged edge: two falling edges on req_i[1] before its START -> missed_o[1] pulses once; exactly one job is served.
- Re-post during service: req_i[0] falling edge during BUSY of its own grant -> pending[0] re-set; served again after the other pending requesters.
- Reset in BUSY: assert reset low mid-job -> all outputs 0 immediately; after release no ack is issued; a new edge is served normally.
- Timeout (with AES_REQ_SCHEDULER_TIMEOUT_EN, TIMEOUT_CYC=8): core_done never asserted -> timeout_o pulse 8 cycles into BUSY, no ack; the next pending requester is granted.
